seg_play_timer: RTL and testbench

Multiplexed seven-segment driver for the piano's playback panel: keeps an elapsed-play timer in BCD (mm:ss, 00:00–99:59) advanced by the one-second tick, and scans it together with the current song number across a parametrised bank of digits. It sits between the song/playback controller and the board's segment/anode pins, and generalises the single-digit per-second stepper into a full counter-plus-scanner with run/pause/clear control.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_decode.sv | 26 ++
 rtl/seg_play_timer.sv | 169 ++++++++++++++++
 tb/tb_seg_play_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants: digit glyphs, blank code, digit-map slots and BCD limits.
package seg_pkg;

  // Glyphs are {g,f,e,d,c,b,a}; dp is handled separately by the top.
  localparam logic [6:0] SEG_D0    = 7'h3F;
  localparam logic [6:0] SEG_D1    = 7'h06;
  localparam logic [6:0] SEG_D2    = 7'h5B;
  localparam logic [6:0] SEG_D3    = 7'h4F;
  localparam logic [6:0] SEG_D4    = 7'h66;
  localparam logic [6:0] SEG_D5    = 7'h6D;
  localparam logic [6:0] SEG_D6    = 7'h7D;
  localparam logic [6:0] SEG_D7    = 7'h07;
  localparam logic [6:0] SEG_D8    = 7'h7F;
  localparam logic [6:0] SEG_D9    = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  localparam logic [2:0] IDX_S0     = 3'd0;
  localparam logic [2:0] IDX_S1     = 3'd1;
  localparam logic [2:0] IDX_M0     = 3'd2;
  localparam logic [2:0] IDX_M1     = 3'd3;
  localparam logic [2:0] IDX_SONG_U = 3'd6;
  localparam logic [2:0] IDX_SONG_T = 3'd7;

endpackage

// File: rtl/seg_decode.sv
// BCD code to seven-segment glyph; codes 10..15 (including the blank code 15) light nothing.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_o = SEG_D0;
      4'd1:    seg_o = SEG_D1;
      4'd2:    seg_o = SEG_D2;
      4'd3:    seg_o = SEG_D3;
      4'd4:    seg_o = SEG_D4;
      4'd5:    seg_o = SEG_D5;
      4'd6:    seg_o = SEG_D6;
      4'd7:    seg_o = SEG_D7;
      4'd8:    seg_o = SEG_D8;
      4'd9:    seg_o = SEG_D9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_play_timer.sv
// mm:ss BCD play timer plus song number, scanned over a bank of seven-segment digits.
// Optional macro SEG_BLINK_EN: paused non-zero timer blinks digits 0-3 once per second.
module seg_play_timer
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int DIGITS     = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1s,
  input  logic              run,
  input  logic              clear,
  input  logic [4:0]        song,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] seg_ctrl,
  output logic              wrap
);

  localparam int DIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
  localparam logic [2:0]        LAST_IDX = 3'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] CTRL_OFF = {DIGITS{ACTIVE_LOW != 0}};

  logic [3:0] s0_q, s1_q, m0_q, m1_q;
  logic [3:0] s0_d, s1_d, m0_d, m1_d;
  logic       wrap_q, wrap_d;

  always_comb begin
    s0_d   = s0_q;
    s1_d   = s1_q;
    m0_d   = m0_q;
    m1_d   = m1_q;
    wrap_d = 1'b0;
    if (clear) begin
      s0_d = 4'd0;
      s1_d = 4'd0;
      m0_d = 4'd0;
      m1_d = 4'd0;
    end else if (tick_1s && run) begin
      if (s0_q != BCD_MAX9) s0_d = s0_q + 4'd1;
      else begin
        s0_d = 4'd0;
        if (s1_q != BCD_MAX5) s1_d = s1_q + 4'd1;
        else begin
          s1_d = 4'd0;
          if (m0_q != BCD_MAX9) m0_d = m0_q + 4'd1;
          else begin
            m0_d = 4'd0;
            if (m1_q != BCD_MAX9) m1_d = m1_q + 4'd1;
            else begin
              m1_d   = 4'd0;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= 4'd0;
      s1_q   <= 4'd0;
      m0_q   <= 4'd0;
      m1_q   <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      m0_q   <= m0_d;
      m1_q   <= m1_d;
      wrap_q <= wrap_d;
    end
  end

  logic blank_time;
`ifdef SEG_BLINK_EN
  logic blink_q;
  logic timer_nz;
  assign timer_nz = |{s0_q, s1_q, m0_q, m1_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    blink_q <= 1'b0;
    else if (run || clear)         blink_q <= 1'b0;
    else if (tick_1s && timer_nz)  blink_q <= ~blink_q;
  end
  assign blank_time = blink_q;
`else
  assign blank_time = 1'b0;
`endif

  // Song index 0..31 split into tens/units by range compare rather than a divider.
  logic [3:0] song_tens, song_units;
  logic [4:0] song_rem;
  always_comb begin
    song_tens = 4'd0;
    song_rem  = song;
    if (song >= 5'd30)      begin song_tens = 4'd3; song_rem = song - 5'd30; end
    else if (song >= 5'd20) begin song_tens = 4'd2; song_rem = song - 5'd20; end
    else if (song >= 5'd10) begin song_tens = 4'd1; song_rem = song - 5'd10; end
    song_units = song_rem[3:0];
  end

  logic [DW-1:0] dwell_q;
  logic [2:0]    scan_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q    <= '0;
      scan_idx_q <= 3'd0;
    end else if (dwell_q == DIV_LAST) begin
      dwell_q    <= '0;
      scan_idx_q <= (scan_idx_q == LAST_IDX) ? 3'd0 : scan_idx_q + 3'd1;
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  logic [3:0] code;
  logic       dp;
  always_comb begin
    code = CODE_BLANK;
    dp   = 1'b0;
    case (scan_idx_q)
      IDX_S0:     code = s0_q;
      IDX_S1:     code = s1_q;
      IDX_M0:     begin code = m0_q; dp = 1'b1; end
      IDX_M1:     code = m1_q;
      IDX_SONG_U: code = song_units;
      IDX_SONG_T: code = (song_tens == 4'd0) ? CODE_BLANK : song_tens;
      default:    code = CODE_BLANK;
    endcase
    if ((blank_time && scan_idx_q <= IDX_M1) || int'(scan_idx_q) >= DIGITS) begin
      code = CODE_BLANK;
      dp   = 1'b0;
    end
  end

  logic [6:0] seg7;
  seg_decode u_decode (
    .code_i (code),
    .seg_o  (seg7)
  );

  logic [DIGITS-1:0] onehot;
  assign onehot = {{(DIGITS-1){1'b0}}, 1'b1} << scan_idx_q;

  // Segment and enable are registered together so a digit never shows its neighbour's glyph.
  logic [7:0]        seg_out_q;
  logic [DIGITS-1:0] seg_ctrl_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out_q  <= SEG_OFF;
      seg_ctrl_q <= CTRL_OFF;
    end else begin
      seg_out_q  <= {dp, seg7} ^ SEG_OFF;
      seg_ctrl_q <= onehot ^ CTRL_OFF;
    end
  end

  assign seg_out  = seg_out_q;
  assign seg_ctrl = seg_ctrl_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_seg_play_timer.sv
// Bench for seg_play_timer: scan walk, timer counting/wrap/clear, song digits, active-low pins.
module tb_seg_play_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1s, run, clear;
  logic [4:0] song;
  logic [7:0] seg_out, seg_out_al;
  logic [7:0] seg_ctrl, seg_ctrl_al;
  logic       wrap, wrap_al;

  seg_play_timer #(.CLK_HZ(800), .SCAN_HZ(10), .DIGITS(8), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .run(run), .clear(clear),
    .song(song), .seg_out(seg_out), .seg_ctrl(seg_ctrl), .wrap(wrap)
  );

  seg_play_timer #(.CLK_HZ(800), .SCAN_HZ(10), .DIGITS(8), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .run(run), .clear(clear),
    .song(song), .seg_out(seg_out_al), .seg_ctrl(seg_ctrl_al), .wrap(wrap_al)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int secs = 0;
  int exp_wraps = 0;
  int wrap_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pat[10];

  always @(negedge clk) if (rst_n === 1'b1 && wrap === 1'b1) wrap_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // One cycle of stimulus; the model applies the timer rules in whole seconds.
  task automatic step(input logic r, input logic c, input logic t);
    run = r; clear = c; tick_1s = t;
    if (c) secs = 0;
    else if (t && r) begin
      secs = secs + 1;
      if (secs == 6000) begin secs = 0; exp_wraps++; end
    end
    @(negedge clk);
  endtask

  task automatic pulse_ticks(input int n, input logic r);
    for (int i = 0; i < n; i++) step(r, 1'b0, 1'b1);
    step(r, 1'b0, 1'b0);
  endtask

  task automatic read_digit(input int d, output logic [7:0] seg);
    logic [7:0] want;
    logic found;
    want = 8'(1) << d;
    found = 1'b0;
    seg = 8'h00;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (seg_ctrl === want) begin seg = seg_out; found = 1'b1; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL digit_timeout digit=%0d actual=%0h required=%0h", d, seg_ctrl, want);
    end
  endtask

  task automatic check_timer(input string name);
    logic [7:0] got, e;
    step(1'b1, 1'b0, 1'b0);
    exp_q.push_back(pat[secs % 10]);
    exp_q.push_back(pat[(secs / 10) % 6]);
    exp_q.push_back(pat[(secs / 60) % 10] | 8'h80);
    exp_q.push_back(pat[secs / 600]);
    for (int d = 0; d < 4; d++) begin
      read_digit(d, got);
      e = exp_q.pop_front();
      chk($sformatf("%s_d%0d", name, d), {24'd0, got}, {24'd0, e});
    end
  endtask

  task automatic check_walk(input int ncyc);
    logic [7:0] e, ne;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e  = 8'(1) << ((k / 10) % 8);
      ne = ~e;
      chk($sformatf("walk_k%0d", k), {24'd0, seg_ctrl}, {24'd0, e});
      chk($sformatf("walk_al_k%0d", k), {24'd0, seg_ctrl_al}, {24'd0, ne});
    end
  endtask

  typedef struct {
    logic [4:0] song;
    logic [7:0] exp_units;
    logic [7:0] exp_tens;
  } song_vec_t;
  song_vec_t vecs[6];

  initial begin
    logic [7:0] got;
    pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    vecs[0] = '{5'd7,  8'h07, 8'h00};
    vecs[1] = '{5'd23, 8'h4F, 8'h5B};
    vecs[2] = '{5'd0,  8'h3F, 8'h00};
    vecs[3] = '{5'd10, 8'h3F, 8'h06};
    vecs[4] = '{5'd31, 8'h06, 8'h4F};
    vecs[5] = '{5'd19, 8'h6F, 8'h06};

    rst_n = 1'b0; tick_1s = 1'b0; run = 1'b0; clear = 1'b0; song = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, seg_out}, 32'h00);
    chk("rst_ctrl", {24'd0, seg_ctrl}, 32'h00);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    chk("rst_seg_al", {24'd0, seg_out_al}, 32'hFF);
    chk("rst_ctrl_al", {24'd0, seg_ctrl_al}, 32'hFF);

    rst_n = 1'b1;
    check_walk(90);

    // Reset in the middle of a dwell: pins go off at once, then dwell restarts fully.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", {24'd0, seg_out}, 32'h00);
    chk("midrst_ctrl", {24'd0, seg_ctrl}, 32'h00);
    chk("midrst_seg_al", {24'd0, seg_out_al}, 32'hFF);
    chk("midrst_ctrl_al", {24'd0, seg_ctrl_al}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    check_walk(20);

    check_timer("zero");

    step(1'b1, 1'b1, 1'b0);
    pulse_ticks(75, 1'b1);
    check_timer("t0115");

    step(1'b1, 1'b1, 1'b0);
    pulse_ticks(42, 1'b1);
    check_timer("t0042");
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("clr_tick_wrap", {31'd0, wrap}, 32'd0);
    check_timer("clr_tick");

    pulse_ticks(37, 1'b1);
    pulse_ticks(10, 1'b0);
    check_timer("paused");

    step(1'b1, 1'b1, 1'b0);
    pulse_ticks(5999, 1'b1);
    check_timer("t9959");
    step(1'b1, 1'b0, 1'b1);
    chk("wrap_hi", {31'd0, wrap}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("wrap_lo", {31'd0, wrap}, 32'd0);
    check_timer("wrapped");

    for (int i = 0; i < 6; i++) begin
      logic [7:0] gu, gt;
      song = vecs[i].song;
      read_digit(6, gu);
      read_digit(7, gt);
      chk($sformatf("song%0d_units", vecs[i].song), {24'd0, gu}, {24'd0, vecs[i].exp_units});
      chk($sformatf("song%0d_tens", vecs[i].song), {24'd0, gt}, {24'd0, vecs[i].exp_tens});
    end

    for (int r = 0; r < 4; r++) begin
      if (r == 1) begin
        step(1'b1, 1'b1, 1'b0);
        pulse_ticks(5990, 1'b1);
      end
      for (int c = 0; c < 300; c++)
        step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 63) == 0),
             logic'($urandom_range(0, 1)));
      check_timer($sformatf("rand%0d", r));
    end

    repeat (3) @(negedge clk);
    chk("wrap_count", wrap_cnt, exp_wraps);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
